// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares one pipelined memory port between I/D block fills and D write-through stores.
module mem_fill_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_miss,
  input  logic [ADDR_W-1:0]                  i_miss_addr,
  input  logic                               d_miss,
  input  logic [ADDR_W-1:0]                  d_miss_addr,
  input  logic                               d_wr_req,
  input  logic [ADDR_W-1:0]                  d_wr_addr,
  input  logic [15:0]                        d_wr_data,
  input  logic [15:0]                        mem_rd_data,
  input  logic                               mem_data_valid,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [15:0]                        mem_wdata,
  output logic                               fill_wr_i,
  output logic                               fill_wr_d,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic [15:0]                        fill_data,
  output logic                               i_done,
  output logic                               d_done,
  output logic                               d_wr_ack,
  output logic                               busy
);
  localparam int CW = $clog2(WORDS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  typedef enum logic [2:0] {IDLE, WRITE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic owner;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0] issue_cnt, ret_cnt;
  logic ret, last_ret, start;
  assign ret      = (state == ISSUE || state == DRAIN) && mem_data_valid;
  assign last_ret = ret && &ret_cnt;
  assign start    = state == IDLE && !d_wr_req && (d_miss || i_miss);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = d_wr_req ? WRITE : (d_miss || i_miss) ? ISSUE : IDLE;
      WRITE:   state_nx = IDLE;
      // the last return can arrive before issuing ends when memory is fast
      ISSUE:   state_nx = last_ret ? DONE : &issue_cnt ? DRAIN : ISSUE;
      DRAIN:   state_nx = last_ret ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      base      <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        owner     <= d_miss;
        base      <= (d_miss ? d_miss_addr : i_miss_addr) & BLOCK_MASK;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (state == ISSUE) issue_cnt <= issue_cnt + 1'b1;
        if (ret) ret_cnt <= ret_cnt + 1'b1;
      end
    end
  end
  assign mem_en    = state == WRITE || state == ISSUE;
  assign mem_wr    = state == WRITE;
  assign mem_addr  = state == WRITE ? d_wr_addr : state == ISSUE ? base + ADDR_W'({issue_cnt, 1'b0}) : '0;
  assign mem_wdata = state == WRITE ? d_wr_data : '0;
  assign fill_wr_i = ret && !owner;
  assign fill_wr_d = ret && owner;
  assign fill_word = ret ? ret_cnt : '0;
  assign fill_data = mem_rd_data;
  assign i_done    = state == DONE && !owner;
  assign d_done    = state == DONE && owner;
  assign d_wr_ack  = state == WRITE;
  assign busy      = state != IDLE;
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter: directed vectors against a 4-cycle pipelined memory model with gap/spurious-valid control.
module tb_mem_fill_arbiter;
  logic clk = 1'b0, rst_n;
  logic i_miss, d_miss, d_wr_req, mem_data_valid;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data, mem_rd_data;
  logic mem_en, mem_wr, fill_wr_i, fill_wr_d, i_done, d_done, d_wr_ack, busy;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic [2:0] fill_word;
  int checks = 0, errors = 0;
  int cyc = 0, hold_from = 0, hold_to = 0, spur_at = -1;

  typedef struct {logic [15:0] d; int due;} rq_t;
  rq_t q[$];
  typedef struct {logic dsel; logic [15:0] addr; int g;} mv_t;
  typedef struct {logic [15:0] a; logic [15:0] d;} sv_t;
  mv_t mt[4];
  sv_t st[3];

  mem_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n), .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr), .d_wr_req(d_wr_req),
    .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .mem_rd_data(mem_rd_data),
    .mem_data_valid(mem_data_valid), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .fill_wr_i(fill_wr_i),
    .fill_wr_d(fill_wr_d), .fill_word(fill_word), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // A read accepted in cycle c becomes returnable in cycle c+4; hold window delays returns.
  always begin
    @(negedge clk);
    if (mem_en && !mem_wr) q.push_back('{16'hA000 + ((mem_addr >> 1) & 16'h7), cyc + 4});
    @(posedge clk);
    cyc++;
    #1;
    if (q.size() > 0 && q[0].due <= cyc && !(cyc >= hold_from && cyc < hold_to)) begin
      mem_data_valid = 1'b1;
      mem_rd_data = q[0].d;
      void'(q.pop_front());
    end else if (cyc == spur_at) begin
      mem_data_valid = 1'b1;
      mem_rd_data = 16'hDEAD;
    end else begin
      mem_data_valid = 1'b0;
      mem_rd_data = 16'h0;
    end
  end

  function automatic logic [58:0] snap();
    logic f = fill_wr_i | fill_wr_d;
    return {mem_en, mem_wr, mem_addr, fill_wr_i, fill_wr_d, f ? fill_word : 3'd0,
            f ? fill_data : 16'd0, i_done, d_done, d_wr_ack, busy, mem_wdata};
  endfunction

  function automatic logic [58:0] mk(logic en, logic wr, logic [15:0] a, logic fi, logic fd,
                                     logic [2:0] fw, logic [15:0] fdat, logic id, logic dd,
                                     logic ack, logic bz, logic [15:0] wd);
    return {en, wr, a, fi, fd, fw, fdat, id, dd, ack, bz, wd};
  endfunction

  task automatic chk(input string n, input logic [58:0] g, input logic [58:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, g, e);
    end
  endtask

  // Entered at the start of cycle 0; returns at the start of the cycle after the done pulse.
  task automatic run_fill(input logic dsel, input logic [15:0] addr, input int g);
    logic [15:0] base = addr & 16'hFFF0;
    int w = 0;
    bit dn = 0, ing, fire, ed, iss;
    if (dsel) begin d_miss = 1'b1; d_miss_addr = addr; end
    else begin i_miss = 1'b1; i_miss_addr = addr; end
    if (g > 0) begin hold_from = cyc + g; hold_to = cyc + g + 2; end
    for (int k = 0; k < 40 && !dn; k++) begin
      ing = g > 0 && (k == g || k == g + 1);
      fire = k >= 5 && w < 8 && !ing;
      ed = w == 8;
      iss = k >= 1 && k <= 8;
      @(negedge clk);
      chk($sformatf("fill_%s_%h_k%0d", dsel ? "d" : "i", addr, k), snap(),
          mk(iss, 1'b0, iss ? base + 16'(2 * (k - 1)) : 16'h0, fire && !dsel, fire && dsel,
             fire ? 3'(w) : 3'd0, fire ? 16'hA000 + 16'(w) : 16'h0, ed && !dsel, ed && dsel,
             1'b0, k >= 1, 16'h0));
      if (fire) w++;
      if (ed) dn = 1;
      @(posedge clk); #2;
    end
    if (!dn) begin errors++; $display("FAIL fill_timeout: got no done expected done"); end
    if (dsel) d_miss = 1'b0; else i_miss = 1'b0;
    hold_from = 0;
    hold_to = 0;
  endtask

  initial begin
    mt[0] = '{1'b0, 16'h1236, 0};
    mt[1] = '{1'b1, 16'hFFF2, 0};
    mt[2] = '{1'b1, 16'h2345, 7};
    mt[3] = '{1'b0, 16'h0000, 0};
    st[0] = '{16'h0100, 16'hBEEF};
    st[1] = '{16'hFFFE, 16'h1234};
    st[2] = '{16'h0003, 16'hFFFF};
    rst_n = 1'b0;
    {i_miss, d_miss, d_wr_req, mem_data_valid} = '0;
    {i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data, mem_rd_data} = '0;
    #1 chk("reset", snap(), '0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    foreach (mt[i]) run_fill(mt[i].dsel, mt[i].addr, mt[i].g);
    foreach (st[i]) begin
      d_wr_req = 1'b1; d_wr_addr = st[i].a; d_wr_data = st[i].d;
      @(negedge clk) chk("store_c0", snap(), '0);
      @(posedge clk); #2;
      @(negedge clk) chk("store_c1", snap(), mk(1, 1, st[i].a, 0, 0, 0, 0, 0, 0, 1, 1, st[i].d));
      @(posedge clk); #2;
      d_wr_req = 1'b0;
      @(negedge clk) chk("store_c2", snap(), '0);
      @(posedge clk); #2;
    end
    // simultaneous misses: D first, I sampled in the IDLE cycle after d_done
    i_miss = 1'b1; i_miss_addr = 16'h0040;
    run_fill(1'b1, 16'h8008, 0);
    run_fill(1'b0, 16'h0040, 0);
    // store wins over a simultaneous D miss
    d_wr_req = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'hBEEF;
    d_miss = 1'b1; d_miss_addr = 16'h0208;
    @(posedge clk); #2;
    @(negedge clk) chk("wr_then_miss_c1", snap(), mk(1, 1, 16'h0100, 0, 0, 0, 0, 0, 0, 1, 1, 16'hBEEF));
    @(posedge clk); #2;
    d_wr_req = 1'b0;
    run_fill(1'b1, 16'h0208, 0);
    // spurious valid while idle
    spur_at = cyc + 1;
    @(posedge clk); #2;
    @(negedge clk) chk("spurious_valid", snap(), '0);
    spur_at = -1;
    @(posedge clk); #2;
    // reset in cycle 6 of a D fill
    d_miss = 1'b1; d_miss_addr = 16'h3330;
    repeat (6) begin @(posedge clk); #2; end
    chk("pre_reset", snap(), mk(1, 0, 16'h333A, 0, 1, 3'd1, 16'hA001, 0, 0, 0, 1, 0));
    rst_n = 1'b0;
    d_miss = 1'b0;
    #1 chk("async_reset", snap(), '0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      @(negedge clk) chk($sformatf("post_reset_%0d", k), snap(), '0);
    end
    @(posedge clk); #2;
    run_fill(1'b0, 16'h4444, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
